uart_rx_deser: RTL and testbench

UART_RX_DESER -- requirements
Module: uart_rx_deser

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx_deser.sv | 116 +++++++++++
 tb/tb_uart_rx_deser.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, frame width and receiver FSM encoding.
// The transmitter is expected to reuse the same constants.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int FRAME_BITS           = 8;

    typedef logic [FRAME_BITS-1:0] uart_byte_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Start bit is re-checked half a bit after the edge so later samples land mid-bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic line_sync
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            meta      <= line;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver with a single-entry holding register and valid/ready hand-off.
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | one bit period, then check the stop bit and deliver or flag
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                  CLK_50MHZ,
    input  logic                  RST,
    input  logic                  UART_RX,
    output logic [FRAME_BITS-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READY,
    output logic                  RX_FRAME_ERR,
    output logic                  RX_OVERRUN,
    output logic                  RX_BUSY
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

    logic          rx_s;
    logic          rx_p;
    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [BW-1:0] bit_cnt;
    uart_byte_t    shreg;
    logic          baud_done;
    logic          byte_done;
    logic          stop_bad;

    uart_sync u_sync (
        .clk       (CLK_50MHZ),
        .rst       (RST),
        .line      (UART_RX),
        .line_sync (rx_s)
    );

    assign baud_done = (baud_cnt == BIT_LAST);
    assign byte_done = (state == ST_STOP) && baud_done && rx_s;
    assign stop_bad  = (state == ST_STOP) && baud_done && !rx_s;
    assign RX_BUSY   = (state != ST_IDLE);

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_p     <= 1'b1;
        end else begin
            rx_p <= rx_s;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rx_p && !rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt       <= '0;
                        shreg[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A byte finishing while the consumer takes the old one simply replaces it.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            RX_DATA      <= '0;
            RX_VALID     <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            RX_OVERRUN   <= 1'b0;
        end else begin
            RX_FRAME_ERR <= stop_bad;
            RX_OVERRUN   <= byte_done && RX_VALID && !RX_READY;
            if (byte_done && (!RX_VALID || RX_READY)) begin
                RX_DATA  <= shreg;
                RX_VALID <= 1'b1;
            end else if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames and consumer timing.
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
        .CLK_50MHZ    (clk),
        .RST          (rst),
        .UART_RX      (uart_rx),
        .RX_DATA      (rx_data),
        .RX_VALID     (rx_valid),
        .RX_READY     (rx_ready),
        .RX_FRAME_ERR (rx_frame_err),
        .RX_OVERRUN   (rx_overrun),
        .RX_BUSY      (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t0;
        logic [7:0]  data;
        bit          stop_ok;
        bit          glitch;
    } sent_t;

    sent_t pend[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
        end
    endtask

    // Reference model: frame completion is a fixed delay after the start edge.
    int unsigned cyc = 0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic        m_busy = 1'b0;
    logic        m_ferr = 1'b0;
    logic        m_ovr = 1'b0;
    int          ovr_seen = 0;
    int          ferr_seen = 0;
    int          rises = 0;
    int unsigned rise_cyc = 0;
    logic [7:0]  rise_data = 8'h00;
    logic        prev_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (rst) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
                m_busy  = 1'b0;
                pend.delete();
            end else begin
                bit done;
                done = 1'b0;
                if (pend.size() > 0) begin
                    int unsigned end_off;
                    end_off = pend[0].glitch ? 3 + HALF : LAT;
                    if (cyc == pend[0].t0 + 3) m_busy = 1'b1;
                    if (cyc == pend[0].t0 + end_off) begin
                        m_busy = 1'b0;
                        if (!pend[0].glitch) begin
                            if (pend[0].stop_ok) done = 1'b1;
                            else m_ferr = 1'b1;
                        end
                        if (done && (!m_valid || rx_ready)) begin
                            m_data  = pend[0].data;
                            m_valid = 1'b1;
                        end else if (done) begin
                            m_ovr = 1'b1;
                        end
                        void'(pend.pop_front());
                    end
                end
                if (!done && m_valid && rx_ready) m_valid = 1'b0;
            end
            #1;
            check("valid", int'(rx_valid), int'(m_valid));
            check("data", int'(rx_data), int'(m_data));
            check("busy", int'(rx_busy), int'(m_busy));
            check("frame_err", int'(rx_frame_err), int'(m_ferr));
            check("overrun", int'(rx_overrun), int'(m_ovr));
            if (rx_valid && !prev_valid) begin
                rises++;
                rise_cyc  = cyc;
                rise_data = rx_data;
            end
            prev_valid = rx_valid;
            ovr_seen  += int'(rx_overrun);
            ferr_seen += int'(rx_frame_err);
        end
    end

    bit rand_ready = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready && ($urandom_range(0, 99) < 2)) rx_ready = ~rx_ready;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int rst_at,
                              output int unsigned t0);
        logic [9:0] bits;
        sent_t      s;
        bits = {stop_ok, data, 1'b0};
        @(negedge clk);
        t0 = cyc;
        s.t0 = t0; s.data = data; s.stop_ok = stop_ok; s.glitch = 1'b0;
        pend.push_back(s);
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i != 0) @(negedge clk);
            if (i == rst_at) begin
                rst     = 1'b1;
                uart_rx = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            uart_rx = bits[i / CPB];
        end
    endtask

    task automatic send_glitch(input int low_cycles);
        sent_t s;
        @(negedge clk);
        s.t0 = cyc; s.data = 8'h00; s.stop_ok = 1'b0; s.glitch = 1'b1;
        pend.push_back(s);
        uart_rx = 1'b0;
        repeat (low_cycles) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic zero_counts();
        ovr_seen = 0; ferr_seen = 0; rises = 0;
    endtask

    initial begin
        int unsigned t0;
        int unsigned tdummy;
        repeat (4) @(negedge clk);
        check("reset data", int'(rx_data), 0);
        check("reset valid", int'(rx_valid), 0);
        check("reset busy", int'(rx_busy), 0);
        rst = 1'b0;
        idle(5);

        // A5 with a ready consumer
        rx_ready = 1'b1;
        zero_counts();
        send_frame(8'hA5, 1'b1, -1, t0);
        idle(20);
        check("a5 rises", rises, 1);
        check("a5 data", int'(rise_data), 'hA5);
        check("a5 latency", int'(rise_cyc - t0), 155);
        check("a5 flags", ovr_seen + ferr_seen, 0);

        // two frames into a stalled consumer
        rx_ready = 1'b0;
        zero_counts();
        send_frame(8'h3C, 1'b1, -1, t0);
        send_frame(8'hC3, 1'b1, -1, t0);
        idle(5);
        check("ovr data kept", int'(rx_data), 'h3C);
        check("ovr valid held", int'(rx_valid), 1);
        check("ovr pulses", ovr_seen, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("ovr drained", int'(rx_valid), 0);
        idle(2);

        // bad stop bit, then a good frame
        rx_ready = 1'b1;
        zero_counts();
        send_frame(8'hFF, 1'b0, -1, t0);
        idle(3);
        send_frame(8'h01, 1'b1, -1, t0);
        idle(5);
        check("ferr pulses", ferr_seen, 1);
        check("ferr then rises", rises, 1);
        check("ferr then data", int'(rise_data), 'h01);

        // short low glitch
        zero_counts();
        send_glitch(4);
        idle(HALF + 6);
        check("glitch rises", rises, 0);
        check("glitch flags", ovr_seen + ferr_seen, 0);
        check("glitch busy", int'(rx_busy), 0);

        // reset in the middle of bit 3
        zero_counts();
        send_frame(8'h55, 1'b1, 4 * CPB + HALF, t0);
        check("midrst data", int'(rx_data), 0);
        check("midrst valid", int'(rx_valid), 0);
        check("midrst busy", int'(rx_busy), 0);
        idle(4);
        send_frame(8'h0F, 1'b1, -1, t0);
        idle(5);
        check("after rst rises", rises, 1);
        check("after rst data", int'(rise_data), 'h0F);

        // completion coinciding with acceptance of the pending byte
        rx_ready = 1'b0;
        zero_counts();
        send_frame(8'h11, 1'b1, -1, t0);
        idle(5);
        check("pending 11", int'(rx_data), 'h11);
        fork
            send_frame(8'h22, 1'b1, -1, tdummy);
            begin
                repeat (LAT) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        idle(5);
        check("swap valid", int'(rx_valid), 1);
        check("swap data", int'(rx_data), 'h22);
        check("swap overrun", ovr_seen, 0);
        rx_ready = 1'b1;
        idle(3);

        // randomized frames, glitches and consumer stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_glitch($urandom_range(1, HALF - 1));
                idle(HALF + 4 + $urandom_range(0, 8));
            end else begin
                send_frame(8'($urandom_range(0, 255)), r != 1, -1, t0);
                idle((r == 1) ? $urandom_range(2, 6) : $urandom_range(0, 6));
            end
        end
        rand_ready = 1'b0;
        @(negedge clk);
        rx_ready = 1'b1;
        idle(LAT + 20);
        check("final idle busy", int'(rx_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
